// File: rtl/eth_wrr_arb_mux.sv
// eth_wrr_arb_mux: S_COUNT-port Ethernet frame mux with frame-granular weighted round-robin (cfg_weight, 0 = off), source-port tag, s_eth_* in / m_eth_* out, 2-register payload skid
module eth_wrr_arb_mux #(
  parameter int S_COUNT = 4,
  parameter int DATA_WIDTH = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter bit USER_ENABLE = 1,
  parameter int USER_WIDTH = 1,
  parameter int WEIGHT_WIDTH = 4,
  parameter int CL_S_COUNT = $clog2(S_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0]  cfg_weight,
  input  logic [S_COUNT-1:0]               s_eth_hdr_valid,
  output logic [S_COUNT-1:0]               s_eth_hdr_ready,
  input  logic [S_COUNT*48-1:0]            s_eth_dest_mac,
  input  logic [S_COUNT*48-1:0]            s_eth_src_mac,
  input  logic [S_COUNT*16-1:0]            s_eth_type,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_eth_payload_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_eth_payload_axis_tkeep,
  input  logic [S_COUNT-1:0]               s_eth_payload_axis_tvalid,
  output logic [S_COUNT-1:0]               s_eth_payload_axis_tready,
  input  logic [S_COUNT-1:0]               s_eth_payload_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]    s_eth_payload_axis_tuser,
  output logic                             m_eth_hdr_valid,
  input  logic                             m_eth_hdr_ready,
  output logic [47:0]                      m_eth_dest_mac,
  output logic [47:0]                      m_eth_src_mac,
  output logic [15:0]                      m_eth_type,
  output logic [CL_S_COUNT-1:0]            m_eth_src_port,
  output logic [DATA_WIDTH-1:0]            m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_eth_payload_axis_tkeep,
  output logic                             m_eth_payload_axis_tvalid,
  input  logic                             m_eth_payload_axis_tready,
  output logic                             m_eth_payload_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_eth_payload_axis_tuser
);
  localparam int BW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;
  typedef enum logic {IDLE, PAYLOAD} state_t;
  state_t state;
  logic [CL_S_COUNT-1:0] grant, last_port, sel;
  logic [CL_S_COUNT-1:0] scan [S_COUNT];
  logic [WEIGHT_WIDTH-1:0] credit;
  logic [S_COUNT-1:0] elig;
  logic cont, go, in_valid, rdy, m_valid, t_valid;
  logic [BW-1:0] in_beat, m_beat, t_beat;
  logic [KEEP_WIDTH-1:0] m_keep;
  logic [USER_WIDTH-1:0] m_user;
  always_comb begin
    elig = '0;
    for (int i = 0; i < S_COUNT; i++) elig[i] = s_eth_hdr_valid[i] && cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0;
    for (int i = 0; i < S_COUNT; i++) scan[i] = CL_S_COUNT'((int'(last_port) + i + 1) % S_COUNT);
    cont = elig[last_port] && credit != '0;
    sel = last_port;
    for (int i = S_COUNT - 1; i >= 0; i--) if (elig[scan[i]]) sel = scan[i];
    if (cont) sel = last_port;
    go = !rst && state == IDLE && (!m_eth_hdr_valid || m_eth_hdr_ready) && |elig;
    s_eth_hdr_ready = go ? {{(S_COUNT-1){1'b0}}, 1'b1} << sel : '0;
    in_beat = {s_eth_payload_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH], s_eth_payload_axis_tkeep[grant*KEEP_WIDTH +: KEEP_WIDTH],
               s_eth_payload_axis_tuser[grant*USER_WIDTH +: USER_WIDTH], s_eth_payload_axis_tlast[grant]};
    in_valid = state == PAYLOAD && s_eth_payload_axis_tvalid[grant] && rdy;
    s_eth_payload_axis_tready = (!rst && state == PAYLOAD) ? {{(S_COUNT-1){1'b0}}, rdy} << grant : '0;
  end
  assign {m_eth_payload_axis_tdata, m_keep, m_user, m_eth_payload_axis_tlast} = m_beat;
  assign m_eth_payload_axis_tkeep = KEEP_ENABLE ? m_keep : '1;
  assign m_eth_payload_axis_tuser = USER_ENABLE ? m_user : '0;
  assign m_eth_payload_axis_tvalid = m_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m_eth_hdr_valid <= 1'b0;
      m_eth_dest_mac <= '0;
      m_eth_src_mac <= '0;
      m_eth_type <= '0;
      m_eth_src_port <= '0;
      grant <= '0;
      last_port <= CL_S_COUNT'(S_COUNT - 1);
      credit <= '0;
      rdy <= 1'b0;
      m_valid <= 1'b0;
      t_valid <= 1'b0;
    end else begin
      if (m_eth_hdr_ready) m_eth_hdr_valid <= 1'b0;
      if (go) begin
        m_eth_hdr_valid <= 1'b1;
        m_eth_dest_mac <= s_eth_dest_mac[sel*48 +: 48];
        m_eth_src_mac <= s_eth_src_mac[sel*48 +: 48];
        m_eth_type <= s_eth_type[sel*16 +: 16];
        m_eth_src_port <= sel;
        grant <= sel;
        last_port <= sel;
        credit <= cont ? credit - 1'b1 : cfg_weight[sel*WEIGHT_WIDTH +: WEIGHT_WIDTH] - 1'b1;
        state <= PAYLOAD;
      end
      if (in_valid && in_beat[0]) state <= IDLE;
      // temp can only fill while rdy is high and m stalls, which drops rdy next cycle, so it never overflows
      rdy <= m_eth_payload_axis_tready || (!m_valid && !t_valid);
      if (rdy) begin
        if (m_eth_payload_axis_tready || !m_valid) begin
          m_valid <= in_valid;
          m_beat <= in_beat;
        end else begin
          t_valid <= in_valid;
          t_beat <= in_beat;
        end
      end else if (m_eth_payload_axis_tready) begin
        m_valid <= t_valid;
        m_beat <= t_beat;
        t_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_eth_wrr_arb_mux.sv
// tb_eth_wrr_arb_mux: randomized frame traffic against a weighted round-robin schedule model and per-port frame scoreboard
module tb_eth_wrr_arb_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] cfg_weight;
  logic [3:0] s_hdr_valid, s_hdr_ready, s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [191:0] s_dest, s_src;
  logic [63:0] s_type;
  logic [31:0] s_tdata;
  logic m_hdr_valid, m_hdr_ready, m_tvalid, m_tready, m_tlast;
  logic [47:0] m_dest, m_src;
  logic [15:0] m_type;
  logic [1:0] m_port;
  logic [7:0] m_tdata;
  logic [0:0] m_tkeep, m_tuser;
  eth_wrr_arb_mux dut (
    .clk(clk), .rst(rst), .cfg_weight(cfg_weight),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type), .m_eth_src_port(m_port),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
    .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser)
  );
  typedef struct packed {logic [47:0] d; logic [47:0] s; logic [15:0] t;} hdr_t;
  typedef struct packed {logic [1:0] p; hdr_t h;} ohdr_t;
  hdr_t hq[4][$];
  hdr_t hlog[4][$];
  logic [9:0] bq[4][$];
  logic [9:0] eb[4][$];
  ohdr_t out_h[$];
  logic [9:0] out_b[$];
  int exp_ports[$];
  int tests_run = 0, tests_failed = 0, cyc = 0, out_frames = 0, viol = 0, hviol = 0, port_err = 0, frame_err = 0, mode = 0;
  logic hdr_hold = 1'b0, rst_req = 1'b1;
  logic [15:0] wcfg = 16'h1111;
  logic [3:0] allow = 4'hf;
  task automatic step();
    @(negedge clk);
    cyc++;
    rst = rst_req;
    cfg_weight = wcfg;
    s_tkeep = 4'hf;
    for (int p = 0; p < 4; p++) begin
      s_hdr_valid[p] = hq[p].size() != 0;
      {s_dest[p*48 +: 48], s_src[p*48 +: 48], s_type[p*16 +: 16]} = '0;
      if (s_hdr_valid[p]) {s_dest[p*48 +: 48], s_src[p*48 +: 48], s_type[p*16 +: 16]} = hq[p][0];
      s_tvalid[p] = bq[p].size() != 0;
      {s_tuser[p], s_tlast[p], s_tdata[p*8 +: 8]} = '0;
      if (s_tvalid[p]) {s_tuser[p], s_tlast[p], s_tdata[p*8 +: 8]} = bq[p][0];
    end
    m_tready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
    m_hdr_ready = !hdr_hold;
    #4;
    for (int p = 0; p < 4; p++) begin
      if (s_hdr_valid[p] && s_hdr_ready[p]) hq[p].delete(0);
      if (s_tvalid[p] && s_tready[p]) bq[p].delete(0);
    end
    if (m_hdr_valid && m_hdr_ready) out_h.push_back({m_port, m_dest, m_src, m_type});
    if (m_tvalid && m_tready) begin
      out_b.push_back({m_tuser, m_tlast, m_tdata});
      if (m_tlast) out_frames++;
    end
    if ((s_tready & ~allow) != 0 || $countones(s_tready) > 1) viol++;
    if (hdr_hold && m_hdr_valid && s_hdr_ready != 0) hviol++;
  endtask
  task automatic clear_q();
    for (int p = 0; p < 4; p++) begin
      hq[p].delete();
      hlog[p].delete();
      bq[p].delete();
      eb[p].delete();
    end
    out_h.delete();
    out_b.delete();
    exp_ports.delete();
    out_frames = 0;
    viol = 0;
    hviol = 0;
  endtask
  task automatic do_reset(input logic [15:0] w);
    rst_req = 1'b1;
    wcfg = w;
    mode = 0;
    hdr_hold = 1'b0;
    allow = 4'hf;
    clear_q();
    repeat (2) step();
    rst_req = 1'b0;
    clear_q();
  endtask
  task automatic add_frame(input int p, input int len);
    hdr_t h;
    logic [9:0] b;
    h.d = {16'($urandom), $urandom};
    h.s = {16'($urandom), $urandom};
    h.t = 16'($urandom);
    hq[p].push_back(h);
    hlog[p].push_back(h);
    for (int i = 0; i < len; i++) begin
      b = {1'($urandom), 1'(i == len - 1), 8'($urandom)};
      bq[p].push_back(b);
      eb[p].push_back(b);
    end
  endtask
  task automatic run(input int nh, input int nf, input int budget);
    int c = 0;
    while ((out_h.size() < nh || out_frames < nf) && c < budget) begin
      step();
      c++;
    end
  endtask
  // schedule when every enabled port always has a frame waiting: each turn is weight[p] frames, ports visited in index order
  task automatic wrr_model(input int start, input int n);
    int p = start;
    int k = 0;
    while (k < n) begin
      for (int j = 0; j < int'(wcfg[p*4 +: 4]) && k < n; j++) begin
        exp_ports.push_back(p);
        k++;
      end
      p = (p + 1) % 4;
    end
  endtask
  task automatic score(input int n);
    int bi = 0;
    ohdr_t o;
    hdr_t e;
    logic [9:0] b, x;
    logic bad;
    port_err = 0;
    frame_err = 0;
    for (int j = 0; j < n; j++) begin
      if (j >= out_h.size()) begin
        port_err++;
        frame_err++;
        continue;
      end
      o = out_h[j];
      if (int'(o.p) != exp_ports[j]) port_err++;
      bad = 1'b0;
      if (hlog[o.p].size() == 0) bad = 1'b1;
      else begin
        e = hlog[o.p].pop_front();
        if (e !== o.h) bad = 1'b1;
      end
      b = '0;
      do begin
        if (bi >= out_b.size() || eb[o.p].size() == 0) begin
          bad = 1'b1;
          break;
        end
        b = out_b[bi];
        bi++;
        x = eb[o.p].pop_front();
        if (b !== x) bad = 1'b1;
      end while (!b[8]);
      if (bad) frame_err++;
    end
  endtask
  task automatic test_reset();
    rst_req = 1'b1;
    wcfg = 16'h1111;
    clear_q();
    add_frame(0, 2);
    step();
    step();
    tests_run++; if (s_hdr_ready !== 4'b0) begin tests_failed++; $display("FAIL reset_hdr_ready: got %b want 0000", s_hdr_ready); end
    tests_run++; if (s_tready !== 4'b0) begin tests_failed++; $display("FAIL reset_tready: got %b want 0000", s_tready); end
    tests_run++; if (m_hdr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_hdr_valid: got %b want 0", m_hdr_valid); end
    tests_run++; if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    tests_run++; if (m_port !== 2'd0) begin tests_failed++; $display("FAIL reset_src_port: got %0d want 0", m_port); end
    tests_run++; if (m_dest !== 48'd0) begin tests_failed++; $display("FAIL reset_dest_mac: got %h want 0", m_dest); end
    rst_req = 1'b0;
    step();
    tests_run++; if (s_hdr_ready !== 4'b0001) begin tests_failed++; $display("FAIL first_grant: got %b want 0001", s_hdr_ready); end
  endtask
  task automatic test_round_robin();
    do_reset(16'h1111);
    for (int p = 0; p < 4; p++) for (int k = 0; k < 12; k++) add_frame(p, 1);
    run(16, 16, 400);
    wrr_model(0, 16);
    score(16);
    tests_run++; if (port_err !== 0) begin tests_failed++; $display("FAIL rr_order: %0d wrong src_port, want 0", port_err); end
    tests_run++; if (frame_err !== 0) begin tests_failed++; $display("FAIL rr_frames: %0d bad frames, want 0", frame_err); end
  endtask
  task automatic test_weighted();
    do_reset(16'h0013);
    mode = 2;
    for (int p = 0; p < 4; p++) for (int k = 0; k < 20; k++) add_frame(p, $urandom_range(1, 4));
    run(16, 16, 2000);
    wrr_model(0, 16);
    score(16);
    tests_run++; if (port_err !== 0) begin tests_failed++; $display("FAIL wrr_order: %0d wrong src_port, want 0", port_err); end
    tests_run++; if (frame_err !== 0) begin tests_failed++; $display("FAIL wrr_frames: %0d bad frames, want 0", frame_err); end
    tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL wrr_tready_onehot: %0d cycles, want 0", viol); end
  endtask
  task automatic test_long_frame();
    do_reset(16'h1111);
    allow = 4'b0100;
    mode = 1;
    add_frame(2, 64);
    run(1, 1, 400);
    mode = 2;
    add_frame(2, 64);
    run(2, 2, 800);
    exp_ports = '{2, 2};
    tests_run++; if (out_b.size() !== 128) begin tests_failed++; $display("FAIL long_beats: got %0d want 128", out_b.size()); end
    score(2);
    tests_run++; if (port_err !== 0) begin tests_failed++; $display("FAIL long_order: %0d wrong src_port, want 0", port_err); end
    tests_run++; if (frame_err !== 0) begin tests_failed++; $display("FAIL long_frames: %0d bad frames, want 0", frame_err); end
    tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL long_other_tready: %0d cycles, want 0", viol); end
  endtask
  task automatic test_hdr_hold();
    int c = 0;
    do_reset(16'h1111);
    add_frame(0, 4);
    add_frame(1, 4);
    hdr_hold = 1'b1;
    while (!m_hdr_valid && c < 20) begin
      step();
      c++;
    end
    repeat (20) step();
    tests_run++; if (out_b.size() !== 4) begin tests_failed++; $display("FAIL hold_payload: got %0d beats want 4", out_b.size()); end
    tests_run++; if (out_h.size() !== 0) begin tests_failed++; $display("FAIL hold_hdr_taken: got %0d want 0", out_h.size()); end
    tests_run++; if (hviol !== 0) begin tests_failed++; $display("FAIL hold_second_hdr: %0d cycles, want 0", hviol); end
    hdr_hold = 1'b0;
    run(2, 2, 100);
    exp_ports = '{0, 1};
    score(2);
    tests_run++; if (port_err !== 0) begin tests_failed++; $display("FAIL hold_order: %0d wrong src_port, want 0", port_err); end
    tests_run++; if (frame_err !== 0) begin tests_failed++; $display("FAIL hold_frames: %0d bad frames, want 0", frame_err); end
  endtask
  task automatic test_reset_mid();
    int c = 0;
    do_reset(16'h1111);
    add_frame(0, 10);
    while (bq[0].size() > 5 && c < 100) begin
      step();
      c++;
    end
    rst_req = 1'b1;
    step();
    step();
    tests_run++; if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_tvalid: got %b want 0", m_tvalid); end
    tests_run++; if (m_hdr_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_hdr_valid: got %b want 0", m_hdr_valid); end
    tests_run++; if (s_tready !== 4'b0) begin tests_failed++; $display("FAIL mid_rst_tready: got %b want 0000", s_tready); end
    tests_run++; if (s_hdr_ready !== 4'b0) begin tests_failed++; $display("FAIL mid_rst_hdr_ready: got %b want 0000", s_hdr_ready); end
    rst_req = 1'b0;
    clear_q();
    add_frame(0, 3);
    run(1, 1, 100);
    exp_ports = '{0};
    score(1);
    tests_run++; if (port_err !== 0) begin tests_failed++; $display("FAIL mid_rst_order: %0d wrong src_port, want 0", port_err); end
    tests_run++; if (frame_err !== 0) begin tests_failed++; $display("FAIL mid_rst_frame: %0d bad frames, want 0", frame_err); end
    tests_run++; if (out_b.size() !== 3) begin tests_failed++; $display("FAIL mid_rst_leftover: got %0d beats want 3", out_b.size()); end
  endtask
  task automatic test_weight_change();
    int c = 0;
    do_reset(16'h1113);
    for (int p = 0; p < 4; p++) for (int k = 0; k < 8; k++) add_frame(p, 6);
    while (hq[0].size() == 8 && c < 20) begin
      step();
      c++;
    end
    wcfg = 16'h1110;
    run(6, 6, 500);
    exp_ports = '{0};
    wrr_model(1, 5);
    score(6);
    tests_run++; if (port_err !== 0) begin tests_failed++; $display("FAIL wchg_order: %0d wrong src_port, want 0", port_err); end
    tests_run++; if (frame_err !== 0) begin tests_failed++; $display("FAIL wchg_frames: %0d bad frames, want 0", frame_err); end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_weighted();
    test_long_frame();
    test_hdr_hold();
    test_reset_mid();
    test_weight_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
